dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter REG_WIDTH, default 32, data and address width.
REQ-002 The block SHALL have parameter DMEM_DEPTH, default 1024, storage depth in 32-bit words.
REQ-003 The block SHALL have parameter DMEM_ADDR_WIDTH, default 10, word-index width, log2(DMEM_DEPTH).
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, range 0-15, extra access cycles per request.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: MEM stage presents a request.
REQ-008 The block SHALL have port req_ready, output, 1 bit: responder can accept a request.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port req_funct3, input, 3 bits: RV32I access size/sign code.
REQ-011 The block SHALL have port req_addr, input, REG_WIDTH bits: byte address.
REQ-012 The block SHALL have port req_wdata, input, REG_WIDTH bits: store data, right-aligned.
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: MEM stage accepts the response.
REQ-015 The block SHALL have port rsp_rdata, output, REG_WIDTH bits: load result, extended.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: access fault flag.

Function
REQ-017 FSM states SHALL be IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance at edge T (req_valid&req_ready) SHALL capture we/funct3/addr/wdata and go to WAIT with counter=WAIT_STATES, or straight to RESP if WAIT_STATES=0.
REQ-019 In WAIT the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP, so rsp_valid first rises at edge T+1+WAIT_STATES.
REQ-020 On entry to RESP, store byte lanes SHALL be written and load data SHALL be registered into rsp_rdata/rsp_err in the same edge.
REQ-021 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid&rsp_ready; that edge SHALL return to IDLE and clear rsp_valid.
REQ-022 Throughput is one request per WAIT_STATES+2 cycles at most; no request SHALL be accepted while WAIT or RESP.
REQ-023 Word index SHALL be addr[DMEM_ADDR_WIDTH+1:2]; byte lane SHALL be addr[1:0].
REQ-024 Stores SHALL support SB=000 (1 lane, wdata[7:0]), SH=001 (2 lanes at addr[1]*2, wdata[15:0]) and SW=010 (all lanes); unwritten lanes SHALL be unchanged.
REQ-025 Loads SHALL support LB=000 and LH=001 (sign-extended), LW=010, and LBU=100 and LHU=101 (zero-extended).
REQ-026 rsp_err SHALL be 1 for a halfword with addr[0]=1, a word with addr[1:0]!=0, an undefined funct3 (load 011/110/111, store 011-111), or addr[REG_WIDTH-1:DMEM_ADDR_WIDTH+2]!=0.
REQ-027 On error no array write SHALL occur and rsp_rdata SHALL be 0; the handshake SHALL complete normally.
REQ-028 Store responses SHALL return rsp_rdata=0.
REQ-029 A load issued after a store response completes SHALL return the stored data, with no stale read.
REQ-030 Input changes while not in IDLE SHALL be ignored.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready SHALL then read 1.
REQ-032 Reset during WAIT SHALL drop the pending request and SHALL NOT commit its store.
REQ-033 Storage array contents SHALL NOT be reset.

Verification
REQ-034 With WAIT_STATES=2: SW addr 0x10 data 0xDEADBEEF accepted at edge 0 -> rsp_valid at edge 3, err 0; then LW 0x10 -> rdata 0xDEADBEEF.
REQ-035 After REQ-034: SB 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-036 LH at 0x13 -> rsp_err 1, rdata 0; SW at 0x12 -> err 1 and word 0x10 unchanged; address 0x1000 (DMEM_DEPTH=1024) -> err 1.
REQ-037 rsp_ready held low 5 cycles in RESP -> rsp_valid, rdata and err stable, req_ready 0; on rsp_ready high, IDLE next cycle.
REQ-038 SW 0x20 0x12345678 with reset_n pulsed low in WAIT -> all outputs at reset values, req_ready 1; subsequent LW 0x20 returns the pre-reset contents.
REQ-039 WAIT_STATES=0: back-to-back requests with rsp_ready tied 1 -> one response per 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time through IDLE -> WAIT -> RESP.
// Latency: the response is registered WAIT_STATES+1 edges after acceptance (at the acceptance edge when WAIT_STATES=0).
// Backpressure: req_ready only in IDLE; the response holds in RESP until rsp_ready.
module dmem_responder #(
   parameter int REG_WIDTH       = 32,
   parameter int DMEM_DEPTH      = 1024,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int WAIT_STATES     = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [REG_WIDTH-1:0] req_addr,
   input  logic [REG_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [REG_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_err
);

   localparam logic [3:0] LP_WS = WAIT_STATES[3:0];

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t               r_state;
   state_t               w_next;
   logic [3:0]           r_cnt;
   logic                 r_we;
   logic [2:0]           r_funct3;
   logic [REG_WIDTH-1:0] r_addr;
   logic [REG_WIDTH-1:0] r_wdata;
   logic [REG_WIDTH-1:0] r_mem [DMEM_DEPTH];

   logic                       w_accept;
   logic                       w_commit;
   logic                       w_acc_we;
   logic [2:0]                 w_acc_funct3;
   logic [REG_WIDTH-1:0]       w_acc_addr;
   logic [REG_WIDTH-1:0]       w_acc_wdata;
   logic [DMEM_ADDR_WIDTH-1:0] w_idx;
   logic [1:0]                 w_lane;
   logic [REG_WIDTH-1:0]       w_word;
   logic [7:0]                 w_byte;
   logic [15:0]                w_half;
   logic [REG_WIDTH-1:0]       w_ld;
   logic [3:0]                 w_wmask;
   logic [REG_WIDTH-1:0]       w_wdat;
   logic                       w_oor;
   logic                       w_err;
   logic                       w_mem_we;

   // With zero wait states the access happens at the acceptance edge, so use the live inputs
   assign w_accept     = (r_state == S_IDLE) && req_valid;
   assign w_commit     = reset_n && ((w_accept && (LP_WS == 4'd0)) || ((r_state == S_WAIT) && (r_cnt == 4'd0)));
   assign w_acc_we     = (r_state == S_IDLE) ? req_we     : r_we;
   assign w_acc_funct3 = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_acc_addr   = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_acc_wdata  = (r_state == S_IDLE) ? req_wdata  : r_wdata;

   // Address decode, fault detection, store lane mask and load extraction
   always_comb begin
      w_idx   = w_acc_addr[DMEM_ADDR_WIDTH+1:2];
      w_lane  = w_acc_addr[1:0];
      w_word  = r_mem[w_idx];
      w_byte  = w_word[{w_lane, 3'b000} +: 8];
      w_half  = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];
      w_oor   = (w_acc_addr >> (DMEM_ADDR_WIDTH + 2)) != '0;
      w_err   = 1'b0;
      w_wmask = 4'b0000;
      w_wdat  = w_acc_wdata;
      w_ld    = '0;
      case (w_acc_funct3)
         3'b000: begin
            w_wmask = 4'b0001 << w_lane;
            w_wdat  = {4{w_acc_wdata[7:0]}};
            w_ld    = {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
         end
         3'b001: begin
            w_err   = w_acc_addr[0];
            w_wmask = w_acc_addr[1] ? 4'b1100 : 4'b0011;
            w_wdat  = {2{w_acc_wdata[15:0]}};
            w_ld    = {{(REG_WIDTH-16){w_half[15]}}, w_half};
         end
         3'b010: begin
            w_err   = (w_acc_addr[1:0] != 2'b00);
            w_wmask = 4'b1111;
            w_ld    = w_word;
         end
         3'b100: begin
            w_err = w_acc_we;
            w_ld  = {{(REG_WIDTH-8){1'b0}}, w_byte};
         end
         3'b101: begin
            w_err = w_acc_we | w_acc_addr[0];
            w_ld  = {{(REG_WIDTH-16){1'b0}}, w_half};
         end
         default: w_err = 1'b1;
      endcase
      if (w_oor) begin
         w_err = 1'b1;
      end
      w_mem_we = w_commit && w_acc_we && !w_err;
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req_valid) w_next = (LP_WS == 4'd0) ? S_RESP : S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      req_ready = (r_state == S_IDLE);
      rsp_valid = (r_state == S_RESP);
   end

   // Request capture and wait-state countdown
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= 4'd0;
         r_we     <= 1'b0;
         r_funct3 <= 3'b000;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else if (w_accept) begin
         r_cnt    <= LP_WS;
         r_we     <= req_we;
         r_funct3 <= req_funct3;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Response data registered on entry to RESP, held until the next commit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (w_commit) begin
         rsp_rdata <= (w_acc_we || w_err) ? '0 : w_ld;
         rsp_err   <= w_err;
      end
   end

   // Storage array: byte-lane writes, contents survive reset
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wmask[b]) begin
               r_mem[w_idx][b*8 +: 8] <= w_wdat[b*8 +: 8];
            end
         end
      end
   end

endmodule
